// File: rtl/sparse_chunk_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sparse_chunk_encoder_pkg
// Purpose  : Shared defaults and state encoding for the sparse chunk encoder.
//            It provides the default chunk and bus geometry, and the
//            FILL/HOLD/EMIT state enum used by the top-level controller.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sparse_chunk_encoder_pkg;

  localparam int DEFAULT_MEM_SIZE = 128;
  localparam int DEFAULT_BUS_SIZE = 8;
  localparam int DEFAULT_BEAT_NUM = DEFAULT_MEM_SIZE / DEFAULT_BUS_SIZE;

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_HOLD = 2'd1,
    ST_EMIT = 2'd2
  } enc_state_e;

endpackage
`default_nettype wire

// File: rtl/sparse_beat_compactor.sv
`default_nettype none
// ============================================================================
// Module   : sparse_beat_compactor
// Purpose  : Combinational analysis of one dense beat. For every byte it
//            gives a nonzero flag, the number of nonzero bytes below it
//            (its offset in the packed stream), and the popcount of the beat.
// Ports    : data_i     - BUS_SIZE dense bytes, byte b at [8*b +: 8]
//            map_o      - per-byte nonzero flag
//            popcount_o - number of nonzero bytes in the beat
//            offset_o   - per-byte count of nonzero bytes at lower positions
// Revision : 1.0 - initial release
// ============================================================================
module sparse_beat_compactor
  import sparse_chunk_encoder_pkg::*;
#(
  parameter int  BUS_SIZE = DEFAULT_BUS_SIZE,
  localparam int OFF_W    = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1,
  localparam int PC_W     = $clog2(BUS_SIZE + 1)
) (
  input  logic [BUS_SIZE*8-1:0]           data_i,
  output logic [BUS_SIZE-1:0]             map_o,
  output logic [PC_W-1:0]                 popcount_o,
  output logic [BUS_SIZE-1:0][OFF_W-1:0]  offset_o
);

  generate
    for (genvar b = 0; b < BUS_SIZE; b++) begin : g_map
      assign map_o[b] = |data_i[8*b +: 8];
    end
  endgenerate

  // Running prefix sum: each byte's offset is taken before its own flag is
  // added, so the lowest nonzero byte lands at offset 0.
  always_comb begin
    logic [PC_W-1:0] acc;
    acc      = '0;
    offset_o = '0;
    for (int b = 0; b < BUS_SIZE; b++) begin
      offset_o[b] = OFF_W'(acc);
      acc         = acc + PC_W'(map_o[b]);
    end
    popcount_o = acc;
  end

endmodule
`default_nettype wire

// File: rtl/sparse_chunk_encoder.sv
`default_nettype none
// ============================================================================
// Module   : sparse_chunk_encoder
// Purpose  : Accepts a chunk of MEM_SIZE dense bytes as BEAT_NUM beats,
//            builds a sparse map and a packed nonzero-byte stream, then
//            replays them as BEAT_NUM registered beats once the downstream
//            buffer is free. Emission targets alternate between two buffers.
// Ports    : CLK, RESET          - clock, synchronous active-high reset
//            in_valid_i/in_ready_o/in_data_i - dense beat input handshake
//            emit_en_i           - downstream buffer free
//            wr_valid_o, wr_count_o, sparsemap_o, nonzero_data_o, wr_sel_o
//                                - sparse beat output stream
//            nnz_count_o         - nonzero count of the last filled chunk
//            chunk_done_o        - pulse after the final emitted beat
// Revision : 1.0 - initial release
// ============================================================================
module sparse_chunk_encoder
  import sparse_chunk_encoder_pkg::*;
#(
  parameter int  MEM_SIZE = DEFAULT_MEM_SIZE,
  parameter int  BUS_SIZE = DEFAULT_BUS_SIZE,
  localparam int BEAT_NUM = MEM_SIZE / BUS_SIZE,
  localparam int CNT_W    = $clog2(BEAT_NUM),
  localparam int PTR_W    = $clog2(MEM_SIZE) + 1
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [BUS_SIZE*8-1:0] in_data_i,
  input  logic                  emit_en_i,
  output logic                  wr_valid_o,
  output logic [CNT_W-1:0]      wr_count_o,
  output logic [BUS_SIZE-1:0]   sparsemap_o,
  output logic [BUS_SIZE*8-1:0] nonzero_data_o,
  output logic                  wr_sel_o,
  output logic [PTR_W-1:0]      nnz_count_o,
  output logic                  chunk_done_o
);

  localparam int AW    = $clog2(MEM_SIZE);
  localparam int OFF_W = (BUS_SIZE > 1) ? $clog2(BUS_SIZE) : 1;
  localparam int PC_W  = $clog2(BUS_SIZE + 1);

  enc_state_e              state_q, state_d;
  logic [CNT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [PTR_W-1:0]        wptr_q, wptr_d;
  logic [PTR_W-1:0]        nnz_q, nnz_d;
  logic [7:0]              pk_q [MEM_SIZE];
  logic [7:0]              pk_d [MEM_SIZE];
  logic [MEM_SIZE-1:0]     map_q, map_d;
  logic                    wr_valid_q, wr_valid_d;
  logic [CNT_W-1:0]        wr_count_q, wr_count_d;
  logic [BUS_SIZE-1:0]     smap_q, smap_d;
  logic [BUS_SIZE*8-1:0]   nzdata_q, nzdata_d;
  logic                    wr_sel_q, wr_sel_d;
  logic                    done_q, done_d;

  logic [BUS_SIZE-1:0]             beat_map;
  logic [PC_W-1:0]                 beat_pop;
  logic [BUS_SIZE-1:0][OFF_W-1:0]  beat_off;

  logic [CNT_W-1:0]        load_beat;
  logic [BUS_SIZE-1:0]     load_map;
  logic [BUS_SIZE*8-1:0]   load_data;

  sparse_beat_compactor #(
    .BUS_SIZE (BUS_SIZE)
  ) u_compactor (
    .data_i     (in_data_i),
    .map_o      (beat_map),
    .popcount_o (beat_pop),
    .offset_o   (beat_off)
  );

  // Slice of the stored chunk that the output registers load next: beat 0
  // when leaving HOLD, otherwise the beat after the one being shown.
  // Packed slots at or beyond the nonzero count may hold stale bytes from a
  // previous chunk, so they are forced to zero here.
  always_comb begin
    logic [AW-1:0] idx;
    load_beat = (state_q == ST_EMIT) ? wr_count_q + CNT_W'(1) : '0;
    load_map  = '0;
    load_data = '0;
    idx       = '0;
    for (int b = 0; b < BUS_SIZE; b++) begin
      idx         = AW'(BUS_SIZE * int'(load_beat) + b);
      load_map[b] = map_q[idx];
      if ({1'b0, idx} < nnz_q) begin
        load_data[8*b +: 8] = pk_q[idx];
      end
    end
  end

  always_comb begin
    logic [AW-1:0] widx;
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    wptr_d     = wptr_q;
    nnz_d      = nnz_q;
    pk_d       = pk_q;
    map_d      = map_q;
    wr_valid_d = 1'b0;
    wr_count_d = '0;
    smap_d     = '0;
    nzdata_d   = '0;
    wr_sel_d   = wr_sel_q;
    done_d     = 1'b0;
    widx       = '0;

    case (state_q)
      ST_FILL: begin
        if (in_valid_i) begin
          for (int b = 0; b < BUS_SIZE; b++) begin
            widx        = AW'(BUS_SIZE * int'(beat_cnt_q) + b);
            map_d[widx] = beat_map[b];
            if (beat_map[b]) begin
              pk_d[AW'(wptr_q) + AW'(beat_off[b])] = in_data_i[8*b +: 8];
            end
          end
          wptr_d = wptr_q + PTR_W'(beat_pop);
          if (beat_cnt_q == CNT_W'(BEAT_NUM - 1)) begin
            state_d    = ST_HOLD;
            beat_cnt_d = '0;
            nnz_d      = wptr_q + PTR_W'(beat_pop);
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end

      ST_HOLD: begin
        if (emit_en_i) begin
          state_d    = ST_EMIT;
          wr_valid_d = 1'b1;
          wr_count_d = '0;
          smap_d     = load_map;
          nzdata_d   = load_data;
        end
      end

      ST_EMIT: begin
        if (wr_count_q == CNT_W'(BEAT_NUM - 1)) begin
          state_d  = ST_FILL;
          wptr_d   = '0;
          done_d   = 1'b1;
          wr_sel_d = ~wr_sel_q;
        end else begin
          wr_valid_d = 1'b1;
          wr_count_d = load_beat;
          smap_d     = load_map;
          nzdata_d   = load_data;
        end
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_FILL;
      beat_cnt_q <= '0;
      wptr_q     <= '0;
      nnz_q      <= '0;
      wr_valid_q <= 1'b0;
      wr_count_q <= '0;
      smap_q     <= '0;
      nzdata_q   <= '0;
      wr_sel_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      wptr_q     <= wptr_d;
      nnz_q      <= nnz_d;
      wr_valid_q <= wr_valid_d;
      wr_count_q <= wr_count_d;
      smap_q     <= smap_d;
      nzdata_q   <= nzdata_d;
      wr_sel_q   <= wr_sel_d;
      done_q     <= done_d;
    end
  end

  // Chunk storage is not reset: every map bit is rewritten on each fill and
  // stale packed bytes are masked by the nonzero count on the way out.
  always_ff @(posedge CLK) begin
    map_q <= map_d;
    pk_q  <= pk_d;
  end

  assign in_ready_o     = (state_q == ST_FILL);
  assign wr_valid_o     = wr_valid_q;
  assign wr_count_o     = wr_count_q;
  assign sparsemap_o    = smap_q;
  assign nonzero_data_o = nzdata_q;
  assign wr_sel_o       = wr_sel_q;
  assign nnz_count_o    = nnz_q;
  assign chunk_done_o   = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sparse_chunk_encoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sparse_chunk_encoder
// Purpose  : Self-checking bench for sparse_chunk_encoder. Stimulus fills
//            chunks and pushes the expected sparse beats into a queue; a
//            negedge monitor pops and compares every emitted beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sparse_chunk_encoder;

  localparam int MEM_SIZE = 128;
  localparam int BUS_SIZE = 8;
  localparam int BEAT_NUM = 16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [63:0] in_data_i = '0;
  logic        emit_en_i = 1'b0;
  logic        wr_valid_o;
  logic [3:0]  wr_count_o;
  logic [7:0]  sparsemap_o;
  logic [63:0] nonzero_data_o;
  logic        wr_sel_o;
  logic [7:0]  nnz_count_o;
  logic        chunk_done_o;

  sparse_chunk_encoder #(
    .MEM_SIZE (MEM_SIZE),
    .BUS_SIZE (BUS_SIZE)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_data_i      (in_data_i),
    .emit_en_i      (emit_en_i),
    .wr_valid_o     (wr_valid_o),
    .wr_count_o     (wr_count_o),
    .sparsemap_o    (sparsemap_o),
    .nonzero_data_o (nonzero_data_o),
    .wr_sel_o       (wr_sel_o),
    .nnz_count_o    (nnz_count_o),
    .chunk_done_o   (chunk_done_o)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  map;
    logic [63:0] data;
    logic [3:0]  cnt;
    logic        sel;
    logic [7:0]  nnz;
  } exp_beat_t;

  exp_beat_t  exp_q[$];
  int         n_checks = 0;
  int         n_pass = 0;
  logic [7:0] chunk_buf [MEM_SIZE];
  logic       sel_model = 1'b0;
  bit         mon_en = 1'b0;
  bit         exp_done = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Scoreboard monitor
  always @(negedge CLK) begin
    exp_beat_t e;
    if (!mon_en) begin
      exp_q.delete();
      exp_done = 1'b0;
    end else begin
      chk("chunk_done", {63'd0, chunk_done_o}, {63'd0, exp_done});
      exp_done = 1'b0;
      if (wr_valid_o) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wr_valid", {63'd0, wr_valid_o}, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_count", {60'd0, wr_count_o}, {60'd0, e.cnt});
          chk("sparsemap", {56'd0, sparsemap_o}, {56'd0, e.map});
          chk("nonzero_data", nonzero_data_o, e.data);
          chk("wr_sel", {63'd0, wr_sel_o}, {63'd0, e.sel});
          chk("nnz_count", {56'd0, nnz_count_o}, {56'd0, e.nnz});
          exp_done = (e.cnt == 4'(BEAT_NUM - 1));
        end
      end else begin
        chk("idle_sparsemap", {56'd0, sparsemap_o}, 64'd0);
        chk("idle_data", nonzero_data_o, 64'd0);
      end
    end
  end

  // Reference model: the packed stream is simply the nonzero bytes of the
  // chunk in order; beat k shows stream slots 8k..8k+7 (zero past the end).
  task automatic push_expected();
    logic [7:0] pk_list[$];
    exp_beat_t  e;
    int         nnz;
    int         i;
    pk_list = {};
    for (int j = 0; j < MEM_SIZE; j++)
      if (chunk_buf[j] != 8'h00) pk_list.push_back(chunk_buf[j]);
    nnz = pk_list.size();
    for (int k = 0; k < BEAT_NUM; k++) begin
      e = '0;
      e.cnt = 4'(k);
      e.sel = sel_model;
      e.nnz = 8'(nnz);
      for (int b = 0; b < BUS_SIZE; b++) begin
        i = BUS_SIZE * k + b;
        e.map[b] = (chunk_buf[i] != 8'h00);
        e.data[8*b +: 8] = (i < nnz) ? pk_list[i] : 8'h00;
      end
      exp_q.push_back(e);
    end
    sel_model = ~sel_model;
  endtask

  // Drives one chunk; returns at the negedge after the final beat is accepted.
  task automatic send_chunk(input int gap_pct);
    logic rdy;
    int   tries;
    push_expected();
    for (int k = 0; k < BEAT_NUM; k++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        in_valid_i = 1'b0;
        in_data_i  = {$urandom, $urandom};
        @(negedge CLK);
      end
      in_valid_i = 1'b1;
      for (int b = 0; b < BUS_SIZE; b++) in_data_i[8*b +: 8] = chunk_buf[BUS_SIZE*k + b];
      tries = 0;
      do begin
        rdy = in_ready_o;
        @(negedge CLK);
        tries++;
      end while (!rdy && tries < 200);
      if (!rdy) chk("in_ready_timeout", {63'd0, in_ready_o}, 64'd1);
    end
    in_valid_i = 1'b0;
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (!chunk_done_o && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk("done_seen", {63'd0, chunk_done_o}, 64'd1);
    chk("ready_after_done", {63'd0, in_ready_o}, 64'd1);
  endtask

  task automatic fill_random();
    int d;
    d = $urandom_range(0, 100);
    for (int j = 0; j < MEM_SIZE; j++)
      chunk_buf[j] = ($urandom_range(0, 99) < d) ? 8'($urandom_range(1, 255)) : 8'h00;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    // Reset state
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    chk("rst_wr_valid", {63'd0, wr_valid_o}, 64'd0);
    chk("rst_wr_count", {60'd0, wr_count_o}, 64'd0);
    chk("rst_sparsemap", {56'd0, sparsemap_o}, 64'd0);
    chk("rst_data", nonzero_data_o, 64'd0);
    chk("rst_wr_sel", {63'd0, wr_sel_o}, 64'd0);
    chk("rst_nnz", {56'd0, nnz_count_o}, 64'd0);
    chk("rst_done", {63'd0, chunk_done_o}, 64'd0);
    RESET = 1'b0;
    @(negedge CLK);
    mon_en = 1'b1;
    emit_en_i = 1'b1;

    // All-nonzero chunk: one HOLD cycle, then emission
    for (int j = 0; j < MEM_SIZE; j++) chunk_buf[j] = 8'h05;
    send_chunk(0);
    chk("hold_ready_low", {63'd0, in_ready_o}, 64'd0);
    chk("hold_valid_low", {63'd0, wr_valid_o}, 64'd0);
    chk("full_nnz", {56'd0, nnz_count_o}, 64'd128);
    @(negedge CLK);
    chk("emit_after_hold", {63'd0, wr_valid_o}, 64'd1);
    wait_done();
    chk("wr_sel_toggled", {63'd0, wr_sel_o}, 64'd1);

    // All-zero chunk
    for (int j = 0; j < MEM_SIZE; j++) chunk_buf[j] = 8'h00;
    send_chunk(10);
    wait_done();
    chk("zero_nnz", {56'd0, nnz_count_o}, 64'd0);

    // Odd bytes of beat 0 nonzero, rest zero
    for (int j = 0; j < MEM_SIZE; j++) chunk_buf[j] = 8'h00;
    chunk_buf[1] = 8'h11; chunk_buf[3] = 8'h22; chunk_buf[5] = 8'h33; chunk_buf[7] = 8'h44;
    send_chunk(0);
    wait_done();
    chk("sparse_nnz", {56'd0, nnz_count_o}, 64'd4);

    // Random chunks back-to-back with input gaps
    for (int c = 0; c < 8; c++) begin
      fill_random();
      send_chunk(30);
      wait_done();
    end

    // Downstream busy: chunk waits in HOLD and ignores new input
    emit_en_i = 1'b0;
    fill_random();
    send_chunk(20);
    for (int c = 0; c < 20; c++) begin
      in_valid_i = 1'b1;
      in_data_i  = {$urandom, $urandom};
      chk("hold_in_ready", {63'd0, in_ready_o}, 64'd0);
      chk("hold_wr_valid", {63'd0, wr_valid_o}, 64'd0);
      @(negedge CLK);
    end
    in_valid_i = 1'b0;
    emit_en_i  = 1'b1;
    chk("hold_no_early", {63'd0, wr_valid_o}, 64'd0);
    @(negedge CLK);
    chk("emit_one_edge", {63'd0, wr_valid_o}, 64'd1);
    wait_done();

    // Reset during emission at beat 7
    fill_random();
    send_chunk(0);
    t = 0;
    while (!(wr_valid_o && wr_count_o == 4'd7) && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("beat7_reached", {60'd0, wr_count_o}, 64'd7);
    RESET  = 1'b1;
    mon_en = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    sel_model = 1'b0;
    chk("mid_rst_wr_valid", {63'd0, wr_valid_o}, 64'd0);
    chk("mid_rst_wr_sel", {63'd0, wr_sel_o}, 64'd0);
    chk("mid_rst_done", {63'd0, chunk_done_o}, 64'd0);
    chk("mid_rst_in_ready", {63'd0, in_ready_o}, 64'd1);
    @(negedge CLK);
    chk("post_rst_done", {63'd0, chunk_done_o}, 64'd0);
    mon_en = 1'b1;

    // Fresh chunk after reset starts from buffer select 0
    fill_random();
    send_chunk(15);
    wait_done();

    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge CLK);
      t++;
    end
    chk("pending_beats", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
